// File: rtl/button_repeat.sv
`default_nettype none
// ============================================================================
// Module   : button_repeat
// Purpose  : Turns debounced button levels into single-cycle step pulses for
//            the EQ parameter-edit logic. A press gives one immediate step,
//            a second step after FIRST_DELAY cycles, then one step every
//            REPEAT_PERIOD cycles until release. Only one button (the lowest
//            index pressed from idle) owns the block at a time.
// Ports    : clock      - system clock
//            reset      - asynchronous reset, active low (0 = in reset)
//            clean      - debounced button levels, 1 = pressed
//            step       - one-hot single-cycle step pulse for the owner
//            held       - one-hot owner indicator
//            repeating  - high while auto-repeat is running
// Macro    : BUTTON_REPEAT_ACCEL_EN - after ACCEL_COUNT repeat steps the
//            repeat period drops to REPEAT_PERIOD/4 for the rest of the hold.
// Revision : 1.0 - initial release
// ============================================================================
module button_repeat #(
    parameter int N_BTN         = 4,
    parameter int FIRST_DELAY   = 13500000,
    parameter int REPEAT_PERIOD = 2700000,
    parameter int CNT_W         = 24,
    parameter int ACCEL_COUNT   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] clean,
    output logic [N_BTN-1:0] step,
    output logic [N_BTN-1:0] held,
    output logic             repeating
);

    // Elaboration-time sanity checks on the configuration.
    generate
        if (FIRST_DELAY < 2 || REPEAT_PERIOD < 4 || ACCEL_COUNT < 1 ||
            (FIRST_DELAY - 1) >= (2 ** CNT_W)) begin : g_param_check
            $error("button_repeat: invalid parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {
        LOCKOUT = 2'd0,
        IDLE    = 2'd1,
        ARMED   = 2'd2,
        REPEAT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_FIRST_TC  = CNT_W'(FIRST_DELAY - 1);
    localparam logic [CNT_W-1:0] c_REPEAT_TC = CNT_W'(REPEAT_PERIOD - 1);

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [N_BTN-1:0] r_held, w_held;
    logic [N_BTN-1:0] r_step, w_step;
    logic             r_rep, w_rep;
    logic [N_BTN-1:0] w_pick;
    logic             w_found;
    logic             w_owner_on;
    logic [CNT_W-1:0] w_period_tc;

`ifdef BUTTON_REPEAT_ACCEL_EN
    localparam int               c_TALLY_W = $clog2(ACCEL_COUNT + 1);
    localparam logic [c_TALLY_W-1:0] c_TALLY_MAX = c_TALLY_W'(ACCEL_COUNT);
    localparam logic [CNT_W-1:0] c_FAST_TC = CNT_W'((REPEAT_PERIOD >> 2) - 1);
    logic [c_TALLY_W-1:0] r_tally, w_tally;

    assign w_period_tc = (r_tally == c_TALLY_MAX) ? c_FAST_TC : c_REPEAT_TC;
`else
    assign w_period_tc = c_REPEAT_TC;
`endif

    // Lowest-index pressed button becomes the owner.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (clean[i] && !w_found) begin
                w_pick[i] = 1'b1;
                w_found   = 1'b1;
            end
        end
    end

    assign w_owner_on = |(clean & r_held);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= LOCKOUT;
            r_cnt   <= '0;
            r_held  <= '0;
            r_step  <= '0;
            r_rep   <= 1'b0;
`ifdef BUTTON_REPEAT_ACCEL_EN
            r_tally <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_held  <= w_held;
            r_step  <= w_step;
            r_rep   <= w_rep;
`ifdef BUTTON_REPEAT_ACCEL_EN
            r_tally <= w_tally;
`endif
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_held  = r_held;
        w_step  = '0;
        w_rep   = r_rep;
`ifdef BUTTON_REPEAT_ACCEL_EN
        w_tally = r_tally;
`endif
        case (r_state)
            LOCKOUT: begin
                w_held = '0;
                w_rep  = 1'b0;
                w_cnt  = '0;
                if (clean == '0) begin
                    w_state = IDLE;
                end
            end
            IDLE: begin
                if (w_found) begin
                    w_held  = w_pick;
                    w_step  = w_pick;
                    w_cnt   = '0;
                    w_state = ARMED;
`ifdef BUTTON_REPEAT_ACCEL_EN
                    w_tally = '0;
`endif
                end
            end
            ARMED, REPEAT: begin
                if (!w_owner_on) begin
                    // Release beats a coincident terminal count.
                    w_held  = '0;
                    w_rep   = 1'b0;
                    w_cnt   = '0;
                    w_state = (clean == '0) ? IDLE : LOCKOUT;
`ifdef BUTTON_REPEAT_ACCEL_EN
                    w_tally = '0;
`endif
                end else if (r_state == ARMED && r_cnt == c_FIRST_TC) begin
                    w_step  = r_held;
                    w_cnt   = '0;
                    w_rep   = 1'b1;
                    w_state = REPEAT;
                end else if (r_state == REPEAT && r_cnt == w_period_tc) begin
                    w_step = r_held;
                    w_cnt  = '0;
`ifdef BUTTON_REPEAT_ACCEL_EN
                    if (r_tally != c_TALLY_MAX) begin
                        w_tally = r_tally + 1'b1;
                    end
`endif
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = LOCKOUT;
            end
        endcase
    end

    assign step      = r_step;
    assign held      = r_held;
    assign repeating = r_rep;

endmodule
`default_nettype wire

// File: tb/tb_button_repeat.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_repeat
// Purpose  : Scoreboard bench for button_repeat. Stimulus pushes the expected
//            (cycle, value) of every step pulse; a monitor pops and compares
//            whenever step is non-zero and flags missing or extra pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_repeat;

    localparam int c_N   = 4;
    localparam int c_FD  = 10;
    localparam int c_RP  = 8;
    localparam int c_AC  = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [c_N-1:0] clean = '0;
    logic [c_N-1:0] step;
    logic [c_N-1:0] held;
    logic           repeating;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int             q_cyc[$];
    logic [c_N-1:0] q_val[$];
    logic [c_N-1:0] r_prev_step = '0;

    button_repeat #(
        .N_BTN         (c_N),
        .FIRST_DELAY   (c_FD),
        .REPEAT_PERIOD (c_RP),
        .CNT_W         (8),
        .ACCEL_COUNT   (c_AC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clean     (clean),
        .step      (step),
        .held      (held),
        .repeating (repeating)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_step(input int at, input logic [c_N-1:0] v);
        q_cyc.push_back(at);
        q_val.push_back(v);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (q_cyc.size() > 0 && q_cyc[0] < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_step: got none expected %0h at cycle %0d", q_val[0], q_cyc[0]);
            void'(q_cyc.pop_front());
            void'(q_val.pop_front());
        end
        if (step != '0) begin
            checks++;
            if (q_cyc.size() == 0) begin
                failures++;
                $display("FAIL extra_step: got %0h at cycle %0d expected none", step, cyc);
            end else begin
                if (q_cyc[0] != cyc || q_val[0] != step) begin
                    failures++;
                    $display("FAIL step: got %0h at cycle %0d expected %0h at cycle %0d",
                             step, cyc, q_val[0], q_cyc[0]);
                end
                void'(q_cyc.pop_front());
                void'(q_val.pop_front());
            end
            chk("step_subset_held", 32'((step & ~held) == '0), 32'd1);
            chk("step_not_back_to_back", 32'(r_prev_step == '0), 32'd1);
        end
        r_prev_step <= step;
    end

    int c0;
    int steps_long[$];

    initial begin
        // Reset state
        tick(3);
        chk("reset_step", 32'(step), 32'h0);
        chk("reset_held", 32'(held), 32'h0);
        chk("reset_repeating", 32'(repeating), 32'h0);
        reset = 1'b1;
        tick(3);

        // Tap: one step, held for five cycles
        c0 = cyc;
        clean = 4'b0001;
        expect_step(c0 + 1, 4'b0001);
        tick(1);
        chk("tap_held", 32'(held), 32'h1);
        tick(4);
        chk("tap_held_last", 32'(held), 32'h1);
        chk("tap_repeating", 32'(repeating), 32'h0);
        clean = 4'b0000;
        tick(1);
        chk("tap_released", 32'(held), 32'h0);
        tick(3);

        // Long hold
        c0 = cyc;
        clean = 4'b0100;
`ifdef BUTTON_REPEAT_ACCEL_EN
        steps_long = '{1, 11, 19, 27, 29, 31, 33, 35, 37, 39};
`else
        steps_long = '{1, 11, 19, 27, 35};
`endif
        foreach (steps_long[i]) expect_step(c0 + steps_long[i], 4'b0100);
        tick(10);
        chk("long_not_yet_repeating", 32'(repeating), 32'h0);
        tick(1);
        chk("long_repeating", 32'(repeating), 32'h1);
        chk("long_held", 32'(held), 32'h4);
        tick(29);
        clean = 4'b0000;
        tick(1);
        chk("long_release_held", 32'(held), 32'h0);
        chk("long_release_repeating", 32'(repeating), 32'h0);
        tick(3);

        // Priority and lockout
        c0 = cyc;
        clean = 4'b0110;
        expect_step(c0 + 1, 4'b0010);
        tick(1);
        chk("prio_held", 32'(held), 32'h2);
        tick(3);
        clean = 4'b0100;
        tick(1);
        chk("prio_owner_released", 32'(held), 32'h0);
        tick(15);
        chk("prio_lockout_held", 32'(held), 32'h0);
        clean = 4'b0000;
        tick(2);
        c0 = cyc;
        clean = 4'b0100;
        expect_step(c0 + 1, 4'b0100);
        tick(1);
        chk("prio_fresh_held", 32'(held), 32'h4);
        tick(2);
        clean = 4'b0000;
        tick(3);

        // Reset mid-hold, button kept through reset release
        c0 = cyc;
        clean = 4'b1000;
        expect_step(c0 + 1, 4'b1000);
        tick(3);
        reset = 1'b0;
        #1;
        chk("async_reset_held", 32'(held), 32'h0);
        tick(3);
        reset = 1'b1;
        tick(12);
        chk("reset_held_no_owner", 32'(held), 32'h0);
        clean = 4'b0000;
        tick(2);
        c0 = cyc;
        clean = 4'b1000;
        expect_step(c0 + 1, 4'b1000);
        tick(1);
        chk("reset_repress_held", 32'(held), 32'h8);
        tick(2);
        clean = 4'b0000;
        tick(3);

        // Release coincident with first terminal count
        c0 = cyc;
        clean = 4'b0001;
        expect_step(c0 + 1, 4'b0001);
        tick(10);
        chk("tc_held_before", 32'(held), 32'h1);
        clean = 4'b0000;
        tick(1);
        chk("tc_release_held", 32'(held), 32'h0);
        chk("tc_release_repeating", 32'(repeating), 32'h0);
        tick(5);

        chk("queue_drained", 32'(q_cyc.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
